// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus: cache lookup/update, memory read channel, redirect input
// and the instruction output handshake towards decode.
interface inst_fetcher_if;
    logic [31:0] ic_addr;
    logic        ic_hit;
    logic [31:0] ic_data;
    logic        ic_upd;
    logic [31:0] ic_upd_addr;
    logic [31:0] ic_upd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output ic_addr, ic_upd, ic_upd_addr, ic_upd_data,
        output mem_req, mem_addr,
        output inst_valid, inst_out, inst_pc,
        input  ic_hit, ic_data, mem_done, mem_data,
        input  jump_en, jump_addr, inst_ready
    );

    modport slave (
        input  ic_addr, ic_upd, ic_upd_addr, ic_upd_data,
        input  mem_req, mem_addr,
        input  inst_valid, inst_out, inst_pc,
        output ic_hit, ic_data, mem_done, mem_data,
        output jump_en, jump_addr, inst_ready
    );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the PC, looks up the I-cache every cycle,
// refills it from memory on a miss and hands instructions to decode.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    inst_fetcher_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MEM   = 2'd1,
        S_FILL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        ic_upd_q, ic_upd_d;
    logic [31:0] ic_upd_addr_q, ic_upd_addr_d;
    logic [31:0] ic_upd_data_q, ic_upd_data_d;

    logic        slot_free;
    logic [31:0] pc_step;

    assign slot_free = !inst_valid_q || bus.inst_ready;
    assign pc_step   = (bus.ic_data[1:0] == 2'b11) ? 32'd4 : 32'd2;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_FETCH;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // A redirect in S_FETCH suppresses the miss: the old PC is no longer wanted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (!bus.jump_en && !bus.ic_hit) state_d = S_MEM;
            S_MEM:   if (bus.mem_done) state_d = S_FILL;
            S_FILL:  state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        inst_valid_d  = inst_valid_q;
        inst_out_d    = inst_out_q;
        inst_pc_d     = inst_pc_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        ic_upd_d      = ic_upd_q;
        ic_upd_addr_d = ic_upd_addr_q;
        ic_upd_data_d = ic_upd_data_q;

        if (inst_valid_q && bus.inst_ready) inst_valid_d = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!bus.jump_en) begin
                    if (bus.ic_hit) begin
                        if (slot_free) begin
                            inst_valid_d = 1'b1;
                            inst_out_d   = bus.ic_data;
                            inst_pc_d    = pc_q;
                            pc_d         = pc_q + pc_step;
                        end
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
            end
            S_MEM: begin
                // The fill completes even across a redirect; the data still matches mem_addr.
                if (bus.mem_done) begin
                    mem_req_d     = 1'b0;
                    ic_upd_d      = 1'b1;
                    ic_upd_addr_d = mem_addr_q;
                    ic_upd_data_d = bus.mem_data;
                end
            end
            S_FILL: begin
                ic_upd_d = 1'b0;
            end
            default: begin
                ic_upd_d = 1'b0;
            end
        endcase

        if (bus.jump_en) begin
            pc_d         = bus.jump_addr;
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q          <= RESET_PC;
            inst_valid_q  <= 1'b0;
            inst_out_q    <= 32'h0;
            inst_pc_q     <= 32'h0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            ic_upd_q      <= 1'b0;
            ic_upd_addr_q <= 32'h0;
            ic_upd_data_q <= 32'h0;
        end else if (rdy_in) begin
            pc_q          <= pc_d;
            inst_valid_q  <= inst_valid_d;
            inst_out_q    <= inst_out_d;
            inst_pc_q     <= inst_pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            ic_upd_q      <= ic_upd_d;
            ic_upd_addr_q <= ic_upd_addr_d;
            ic_upd_data_q <= ic_upd_data_d;
        end
    end

    assign bus.ic_addr     = pc_q;
    assign bus.ic_upd      = ic_upd_q;
    assign bus.ic_upd_addr = ic_upd_addr_q;
    assign bus.ic_upd_data = ic_upd_data_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst_out    = inst_out_q;
    assign bus.inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: cache and memory-controller models around the DUT,
// directed scenarios plus a randomized run checked against a program-order model.
module tb_inst_fetcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic force_hit = 1'b0;
    logic prog_alt  = 1'b0;
    logic cache_clr = 1'b0;
    int   mem_lat   = 3;
    int   mem_cnt   = 0;

    logic        c_v   [16];
    logic [26:0] c_tag [16];
    logic [31:0] c_dat [16];

    inst_fetcher_if bus();

    inst_fetcher #(.RESET_PC(32'h0)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Program image: the 32-bit word fetched at any halfword address.
    function automatic logic [31:0] prog(input logic [31:0] a, input logic alt);
        logic [31:0] h;
        if (alt) return (a % 32'd6 == 32'd0) ? 32'h0000_0013 : 32'h0000_4501;
        if (a == 32'h100) return 32'h00A0_0093;
        h = a * 32'h9E37_79B1;
        return {h[31:2], h[7] ? 2'b11 : {1'b0, h[9]}};
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic alt);
        logic [31:0] w;
        w = prog(a, alt);
        return (w[1:0] == 2'b11) ? a + 32'd4 : a + 32'd2;
    endfunction

    // Direct-mapped cache: 16 halfword-indexed entries, combinational lookup.
    always_comb begin
        if (force_hit) begin
            bus.ic_hit  = 1'b1;
            bus.ic_data = prog(bus.ic_addr, prog_alt);
        end else begin
            bus.ic_hit  = c_v[bus.ic_addr[4:1]] && (c_tag[bus.ic_addr[4:1]] == bus.ic_addr[31:5]);
            bus.ic_data = c_dat[bus.ic_addr[4:1]];
        end
    end

    always @(posedge clk) begin
        if (cache_clr) begin
            for (int i = 0; i < 16; i++) c_v[i] <= 1'b0;
        end else if (bus.ic_upd) begin
            c_v[bus.ic_upd_addr[4:1]]   <= 1'b1;
            c_tag[bus.ic_upd_addr[4:1]] <= bus.ic_upd_addr[31:5];
            c_dat[bus.ic_upd_addr[4:1]] <= bus.ic_upd_data;
        end
    end

    // Memory controller: fixed latency, holds mem_done until an enabled edge consumes it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt      <= 0;
            bus.mem_done <= 1'b0;
            bus.mem_data <= 32'h0;
        end else if (bus.mem_done) begin
            if (rdy) bus.mem_done <= 1'b0;
        end else if (bus.mem_req) begin
            if (mem_cnt + 1 >= mem_lat) begin
                bus.mem_done <= 1'b1;
                bus.mem_data <= prog(bus.mem_addr, prog_alt);
                mem_cnt      <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        bus.jump_en = 1'b0;
        bus.inst_ready = 1'b1;
        cache_clr = 1'b1;
        repeat (2) @(negedge clk);
        cache_clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs [9];
        string nm [9];
        rst = 1'b1;
        cache_clr = 1'b1;
        repeat (2) @(negedge clk);
        cache_clr = 1'b0;
        nm = '{"inst_valid", "inst_out", "inst_pc", "mem_req", "mem_addr",
               "ic_upd", "ic_upd_addr", "ic_upd_data", "ic_addr"};
        obs[0] = {31'b0, bus.inst_valid};
        obs[1] = bus.inst_out;
        obs[2] = bus.inst_pc;
        obs[3] = {31'b0, bus.mem_req};
        obs[4] = bus.mem_addr;
        obs[5] = {31'b0, bus.ic_upd};
        obs[6] = bus.ic_upd_addr;
        obs[7] = bus.ic_upd_data;
        obs[8] = bus.ic_addr;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (obs[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset_%s: got %h want %h", nm[i], obs[i], 32'h0);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        force_hit = 1'b1;
        prog_alt = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst_out !== prog(exp_pc, 1'b1)) begin
                bad++;
                $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_out, exp_pc, prog(exp_pc, 1'b1));
            end
            exp_pc = step(exp_pc, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_out;
        force_hit = 1'b1;
        prog_alt = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        total++;
        if (bus.inst_pc !== 32'd6) begin
            bad++;
            $display("FAIL bp_pre: got pc=%h want %h", bus.inst_pc, 32'd6);
        end
        held_out = bus.inst_out;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd6 || bus.inst_out !== held_out ||
                bus.ic_addr !== 32'd10) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%h inst=%h fetch=%h want v=1 pc=6 inst=%h fetch=a",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_out, bus.ic_addr, held_out);
            end
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd10) begin
            bad++;
            $display("FAIL bp_resume: got v=%b pc=%h want v=1 pc=a", bus.inst_valid, bus.inst_pc);
        end
        @(negedge clk);
        total++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd12) begin
            bad++;
            $display("FAIL bp_next: got v=%b pc=%h want v=1 pc=c", bus.inst_valid, bus.inst_pc);
        end
    endtask

    task automatic test_jump_hit();
        force_hit = 1'b1;
        prog_alt = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        bus.jump_addr = 32'h40;
        bus.jump_en = 1'b1;
        @(negedge clk);
        bus.jump_en = 1'b0;
        total++;
        if (bus.inst_valid !== 1'b0 || bus.ic_addr !== 32'h40) begin
            bad++;
            $display("FAIL jump_squash: got v=%b pc=%h want v=0 pc=40", bus.inst_valid, bus.ic_addr);
        end
        @(negedge clk);
        total++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_out !== 32'h4501) begin
            bad++;
            $display("FAIL jump_target: got v=%b pc=%h inst=%h want v=1 pc=40 inst=4501",
                     bus.inst_valid, bus.inst_pc, bus.inst_out);
        end
        @(negedge clk);
        total++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h42) begin
            bad++;
            $display("FAIL jump_follow: got v=%b pc=%h want v=1 pc=42", bus.inst_valid, bus.inst_pc);
        end
    endtask

    // Reset with an empty cache and redirect straight to 0x100 so the next lookup misses.
    task automatic start_miss_at_100(input int lat, output bool_ok);
        int n;
        force_hit = 1'b0;
        prog_alt = 1'b0;
        mem_lat = lat;
        do_reset();
        bus.jump_addr = 32'h100;
        bus.jump_en = 1'b1;
        @(negedge clk);
        bus.jump_en = 1'b0;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || n != 1) begin
            bad++;
            bool_ok = 1'b0;
            $display("FAIL miss_req: got req=%b addr=%h after %0d cycles want req=1 addr=100 after 1",
                     bus.mem_req, bus.mem_addr, n);
        end else begin
            bool_ok = 1'b1;
        end
    endtask

    typedef logic bool_t;
    bool_t bool_ok;

    task automatic test_miss();
        int n;
        start_miss_at_100(3, bool_ok);
        n = 0;
        while (bus.mem_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
                bad++;
                $display("FAIL miss_hold: got req=%b addr=%h want req=1 addr=100", bus.mem_req, bus.mem_addr);
            end
        end
        @(negedge clk);
        total++;
        if (bus.ic_upd !== 1'b1 || bus.ic_upd_addr !== 32'h100 || bus.ic_upd_data !== 32'h00A0_0093 ||
            bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL miss_upd: got upd=%b addr=%h data=%h req=%b want upd=1 addr=100 data=00a00093 req=0",
                     bus.ic_upd, bus.ic_upd_addr, bus.ic_upd_data, bus.mem_req);
        end
        @(negedge clk);
        total++;
        if (bus.ic_upd !== 1'b0) begin
            bad++;
            $display("FAIL miss_upd_pulse: got upd=%b want 0", bus.ic_upd);
        end
        @(negedge clk);
        total++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst_out !== 32'h00A0_0093) begin
            bad++;
            $display("FAIL miss_deliver: got v=%b pc=%h inst=%h want v=1 pc=100 inst=00a00093",
                     bus.inst_valid, bus.inst_pc, bus.inst_out);
        end
    endtask

    task automatic test_jump_in_mem();
        int n;
        bool_t got;
        start_miss_at_100(5, bool_ok);
        bus.jump_addr = 32'h200;
        bus.jump_en = 1'b1;
        @(negedge clk);
        bus.jump_en = 1'b0;
        total++;
        if (bus.ic_addr !== 32'h200 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL jm_redirect: got pc=%h req=%b addr=%h want pc=200 req=1 addr=100",
                     bus.ic_addr, bus.mem_req, bus.mem_addr);
        end
        n = 0;
        while (bus.mem_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL jm_hold: got req=%b addr=%h v=%b want req=1 addr=100 v=0",
                         bus.mem_req, bus.mem_addr, bus.inst_valid);
            end
        end
        @(negedge clk);
        total++;
        if (bus.ic_upd !== 1'b1 || bus.ic_upd_addr !== 32'h100 || bus.ic_upd_data !== 32'h00A0_0093) begin
            bad++;
            $display("FAIL jm_fill: got upd=%b addr=%h data=%h want upd=1 addr=100 data=00a00093",
                     bus.ic_upd, bus.ic_upd_addr, bus.ic_upd_data);
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.inst_valid === 1'b1) begin
                got = 1'b1;
                total++;
                if (bus.inst_pc !== 32'h200 || bus.inst_out !== prog(32'h200, 1'b0)) begin
                    bad++;
                    $display("FAIL jm_first: got pc=%h inst=%h want pc=200 inst=%h",
                             bus.inst_pc, bus.inst_out, prog(32'h200, 1'b0));
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL jm_timeout: got no instruction want pc=200");
        end
    endtask

    task automatic test_rdy_stall();
        int pulses;
        int n;
        start_miss_at_100(3, bool_ok);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.mem_req !== 1'b1 || bus.ic_upd !== 1'b0 || bus.ic_addr !== 32'h100 ||
                bus.inst_valid !== 1'b0 || bus.mem_addr !== 32'h100) begin
                bad++;
                $display("FAIL stall_frozen[%0d]: got req=%b upd=%b pc=%h v=%b want req=1 upd=0 pc=100 v=0",
                         i, bus.mem_req, bus.ic_upd, bus.ic_addr, bus.inst_valid);
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ic_upd !== 1'b1 || bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_done: got upd=%b req=%b want upd=1 req=0", bus.ic_upd, bus.mem_req);
        end
        rdy = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ic_upd !== 1'b1) begin
            bad++;
            $display("FAIL stall_upd_ext: got upd=%b want 1", bus.ic_upd);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (bus.ic_upd === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL stall_upd_count: got %0d enabled pulses want 1", pulses);
        end
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.mem_req !== 1'b0 || bus.ic_addr !== 32'h0 || bus.inst_valid !== 1'b0 || n >= 30) begin
            bad++;
            $display("FAIL async_rst: got req=%b pc=%h v=%b wait=%0d want req=0 pc=0 v=0",
                     bus.mem_req, bus.ic_addr, bus.inst_valid, n);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] r;
        logic        last_req, last_done_en, last_upd_en;
        logic [31:0] last_addr;
        int          delivered;
        force_hit = 1'b0;
        prog_alt = 1'b0;
        mem_lat = 2;
        do_reset();
        exp_pc = 32'h0;
        delivered = 0;
        last_req = 1'b0;
        last_done_en = 1'b0;
        last_upd_en = 1'b0;
        last_addr = 32'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (last_req && !bus.mem_req && !last_done_en) begin
                total++;
                bad++;
                $display("FAIL rnd_req_drop: got req=0 without done want req=1");
            end
            if (last_req && bus.mem_req) begin
                total++;
                if (bus.mem_addr !== last_addr) begin
                    bad++;
                    $display("FAIL rnd_addr_stable: got %h want %h", bus.mem_addr, last_addr);
                end
            end
            if (last_done_en) begin
                total++;
                if (bus.ic_upd !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_upd_after_done: got upd=%b want 1", bus.ic_upd);
                end
            end
            if (last_upd_en) begin
                total++;
                if (bus.ic_upd !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_upd_width: got upd=%b want 0", bus.ic_upd);
                end
            end
            r = $urandom;
            rdy = (r[3:0] != 4'd0);
            bus.inst_ready = (r[5:4] != 2'd0);
            bus.jump_en = rdy && (r[10:6] == 5'd0);
            bus.jump_addr = (r[14:11] == 4'd0) ? {28'hFFFF_FFF, r[17:15], 1'b0}
                                               : {25'b0, r[22:18], 2'b0};
            if (bus.inst_valid === 1'b1 && bus.inst_ready && rdy && !bus.jump_en) begin
                total++;
                if (bus.inst_pc !== exp_pc || bus.inst_out !== prog(exp_pc, 1'b0)) begin
                    bad++;
                    $display("FAIL rnd_inst: got pc=%h inst=%h want pc=%h inst=%h",
                             bus.inst_pc, bus.inst_out, exp_pc, prog(exp_pc, 1'b0));
                end
                exp_pc = step(exp_pc, 1'b0);
                delivered++;
            end
            if (bus.jump_en) exp_pc = bus.jump_addr;
            last_req = bus.mem_req;
            last_addr = bus.mem_addr;
            last_done_en = bus.mem_done && rdy;
            last_upd_en = bus.ic_upd && rdy;
        end
        bus.jump_en = 1'b0;
        rdy = 1'b1;
        total++;
        if (delivered < 50) begin
            bad++;
            $display("FAIL rnd_progress: got %0d delivered want at least 50", delivered);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.jump_en = 1'b0;
        bus.jump_addr = 32'h0;
        bus.inst_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_hit();
        test_miss();
        test_jump_in_mem();
        test_rdy_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
